// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage defaults: datapath width, reset PC and the bubble encoding used by IF/ID.
package fetch_unit_pkg;

  localparam int unsigned DEF_WIDTH = 12;
  localparam int unsigned DEF_DEPTH = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_PC = '0;
  localparam logic [DEF_WIDTH-1:0] INSTR_NOP = '0;

  // Width of a counter that must reach the value n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; combinational head read. Push while full is taken only alongside
// a pop in the same cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order memory requests, buffers returned words
// with their PCs and presents them to IF/ID; redirects flush and drop in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter int unsigned      DEPTH    = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr,
  output logic             fetch_err
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0]   r_fetch_pc;
  logic [CW-1:0]      r_outstanding;
  logic [CW-1:0]      r_drop;
  logic               r_fetch_err;

  logic [2*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   w_rsp_pc;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_sh_count;
  logic               w_empty;
  logic               w_full;
  logic               w_sh_full;
  logic               w_sh_empty;
  logic               w_room;
  logic               w_accept;
  logic               w_rv_cnt;
  logic               w_rsp_ok;
  logic               w_rsp_drop;
  logic               w_pop;
  logic               w_unused;

  // Credits count in-flight requests as occupied so the buffer can never overflow.
  assign w_room     = ({1'b0, w_count} + {1'b0, r_outstanding}) < (CW + 1)'(DEPTH);
  assign imem_req   = !reset && !redirect && w_room;
  assign imem_addr  = r_fetch_pc;
  assign w_accept   = imem_req && imem_ready;

  // A response with nothing outstanding is stray: flagged, never counted or buffered.
  assign w_rv_cnt   = imem_rvalid && (r_outstanding != '0);
  assign w_rsp_ok   = w_rv_cnt && (r_drop == '0) && !redirect;
  assign w_rsp_drop = w_rv_cnt && (r_drop != '0) && !redirect;

  assign if_valid   = !reset && !w_empty;
  assign if_pc      = if_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
  assign if_instr   = if_valid ? w_head[WIDTH-1:0] : '0;
  assign w_pop      = if_valid && !stall;
  assign fetch_err  = r_fetch_err;
  assign w_unused   = ^{w_full, w_sh_full, w_sh_empty, w_sh_count};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fetch_err   <= 1'b0;
    end else begin
      if (redirect)      r_fetch_pc <= redirect_pc;
      else if (w_accept) r_fetch_pc <= r_fetch_pc + 1'b1;

      case ({w_accept, w_rv_cnt})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (redirect)        r_drop <= r_outstanding - CW'(w_rv_cnt);
      else if (w_rsp_drop) r_drop <= r_drop - 1'b1;

      if (imem_rvalid && (r_outstanding == '0)) r_fetch_err <= 1'b1;
    end
  end

  // PC shadow: holds the address of every live (non-dropped) request, oldest first.
  fetch_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_pc_shadow (
    .clk  (clk),
    .reset(reset),
    .push (w_accept),
    .wdata(r_fetch_pc),
    .pop  (w_rsp_ok),
    .flush(redirect),
    .rdata(w_rsp_pc),
    .full (w_sh_full),
    .empty(w_sh_empty),
    .count(w_sh_count)
  );

  fetch_fifo #(
    .WIDTH(2 * WIDTH),
    .DEPTH(DEPTH)
  ) u_prefetch (
    .clk  (clk),
    .reset(reset),
    .push (w_rsp_ok),
    .wdata({w_rsp_pc, imem_rdata}),
    .pop  (w_pop),
    .flush(redirect),
    .rdata(w_head),
    .full (w_full),
    .empty(w_empty),
    .count(w_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: fixed-latency memory model, expected-stream scoreboard and
// directed cycle checks around stall, redirect, wrap, stray responses and reset.
module tb_fetch_unit;

  localparam int unsigned W = 12;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ready;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         stall;
  logic         if_valid;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_instr;
  logic         fetch_err;

  fetch_unit #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RESET_PC(12'h000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] pc; logic [W-1:0] instr; } exp_t;
  typedef struct { logic [W-1:0] addr; int due; } mreq_t;

  exp_t  sb[$];
  mreq_t mq[$];
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    n_pop     = 0;
  int    cyc       = 0;
  int    lat       = 1;
  int    inject_at = -1;
  int    p0;

  function automatic logic [W-1:0] instr_of(input logic [W-1:0] pc);
    return {pc[3:0], pc[11:4]} ^ 12'hC3A;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic expect_stream(input logic [W-1:0] base);
    logic [W-1:0] pc;
    sb.delete();
    pc = base;
    for (int i = 0; i < 100; i++) begin
      sb.push_back('{pc, instr_of(pc)});
      pc = pc + 1'b1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory model: accepted requests answered in order after lat cycles.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) mq.delete();
    else if (imem_req && imem_ready) mq.push_back('{imem_addr, cyc + lat});
  end

  initial begin
    mreq_t m;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        m           = mq.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(m.addr);
      end else if (cyc == inject_at) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 12'hBAD;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Monitor: every consumed instruction must match the head of the expected stream.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && !redirect && if_valid && !stall) begin
      n_pop++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h with nothing expected", if_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    reset       = 1'b1;
    imem_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    expect_stream(12'h000);

    // Reset state
    step(1);
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 12'h000);
    chk("rst_instr", if_instr, 12'h000);
    chk1("rst_err", fetch_err, 1'b0);
    step(1);
    reset = 1'b0;

    // 1: streaming, first word two cycles after first request
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, W'(i));
      if (i < 2) chk1("t1_early_valid", if_valid, 1'b0);
      if (i == 2) begin
        chk1("t1_first_valid", if_valid, 1'b1);
        chk("t1_first_pc", if_pc, 12'h000);
      end
      step(1);
    end
    step(2);

    // 2: stall for 10 cycles
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("t2_hold_valid", if_valid, 1'b1);
      chk("t2_hold_pc", if_pc, sb[0].pc);
      if (i >= 3) chk1("t2_req_blocked", imem_req, 1'b0);
      step(1);
    end
    stall = 1'b0;
    p0 = n_pop;
    step(8);
    chk1("t2_drain", (n_pop - p0) >= 6, 1'b1);

    // 3: redirect with two requests in flight
    lat = 2;
    step(6);
    redirect    = 1'b1;
    redirect_pc = 12'h040;
    expect_stream(12'h040);
    @(negedge clk);
    chk1("t3_req_off", imem_req, 1'b0);
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    chk1("t3_flushed", if_valid, 1'b0);
    chk1("t3_req_on", imem_req, 1'b1);
    chk("t3_addr", imem_addr, 12'h040);
    p0 = n_pop;
    step(8);
    chk1("t3_stream", (n_pop - p0) >= 3, 1'b1);

    // 4: redirect under stall, then back-to-back redirects
    lat   = 1;
    stall = 1'b1;
    step(5);
    redirect    = 1'b1;
    redirect_pc = 12'h100;
    expect_stream(12'h100);
    @(negedge clk);
    chk1("t4_req_off0", imem_req, 1'b0);
    step(1);
    redirect_pc = 12'h200;
    stall       = 1'b0;
    expect_stream(12'h200);
    @(negedge clk);
    chk1("t4_flushed", if_valid, 1'b0);
    chk1("t4_req_off1", imem_req, 1'b0);
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    chk1("t4_empty", if_valid, 1'b0);
    chk1("t4_req_on", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 12'h200);
    p0 = n_pop;
    step(6);
    chk1("t4_stream", (n_pop - p0) >= 3, 1'b1);

    // 5: PC wrap
    redirect    = 1'b1;
    redirect_pc = 12'hFFD;
    expect_stream(12'hFFD);
    step(1);
    redirect = 1'b0;
    p0 = n_pop;
    a  = 12'hFFD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_addr", imem_addr, a);
      a = a + 1'b1;
      step(1);
    end
    step(4);
    chk1("t5_stream", (n_pop - p0) >= 5, 1'b1);

    // 6: stray response, sticky error, reset mid-stream
    imem_ready = 1'b0;
    step(6);
    @(negedge clk);
    chk1("t6_err_clear", fetch_err, 1'b0);
    chk1("t6_drained", if_valid, 1'b0);
    step(1);
    inject_at = cyc + 1;
    step(1);
    @(negedge clk);
    chk1("t6_stray_valid", imem_rvalid, 1'b1);
    step(1);
    @(negedge clk);
    chk1("t6_err_set", fetch_err, 1'b1);
    chk1("t6_stray_ignored", if_valid, 1'b0);
    imem_ready = 1'b1;
    step(6);
    @(negedge clk);
    chk1("t6_err_sticky", fetch_err, 1'b1);
    step(1);
    reset = 1'b1;
    expect_stream(12'h000);
    @(negedge clk);
    chk1("t6_rst_req", imem_req, 1'b0);
    chk1("t6_rst_valid", if_valid, 1'b0);
    chk("t6_rst_pc", if_pc, 12'h000);
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk1("t6_post_valid", if_valid, 1'b0);
    chk1("t6_post_req", imem_req, 1'b1);
    chk("t6_post_addr", imem_addr, 12'h000);
    chk1("t6_post_err", fetch_err, 1'b0);
    p0 = n_pop;
    step(6);
    chk1("t6_stream", (n_pop - p0) >= 3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
